// File: rtl/ctmm_mem_wr_bridge_if.sv
// ----------------------------------------------------------------------------
// ctmm_mem_wr_bridge_if
//   Memory-bus write channel between the C-List write bridge and the memory
//   subsystem. It has one request phase (valid/ready with address and data)
//   and one response phase (a single-cycle valid with an error flag).
//
//   Signals
//     bus_req_valid  bridge -> memory  write request is presented
//     bus_req_ready  memory -> bridge  memory accepts the request this cycle
//     bus_addr       bridge -> memory  64-bit byte address (8-byte aligned)
//     bus_wdata      bridge -> memory  64-bit write data
//     bus_rsp_valid  memory -> bridge  write response is present this cycle
//     bus_rsp_err    memory -> bridge  response carries an error (needs valid)
//
//   Modports
//     master  bridge side (drives the request, samples the response)
//     slave   memory side
// ----------------------------------------------------------------------------
interface ctmm_mem_wr_bridge_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic        bus_rsp_valid;
  logic        bus_rsp_err;

  modport master (
    output bus_req_valid,
    output bus_addr,
    output bus_wdata,
    input  bus_req_ready,
    input  bus_rsp_valid,
    input  bus_rsp_err
  );

  modport slave (
    input  bus_req_valid,
    input  bus_addr,
    input  bus_wdata,
    output bus_req_ready,
    output bus_rsp_valid,
    output bus_rsp_err
  );
endinterface : ctmm_mem_wr_bridge_if

// File: rtl/ctmm_mem_wr_bridge.sv
// ----------------------------------------------------------------------------
// ctmm_mem_wr_bridge
//   Turns a level-held write request from mSave (a Golden Token bound for a
//   C-List slot) into exactly one memory-bus write. It then reports the
//   outcome as a one-cycle done or fault pulse. Misaligned addresses are
//   rejected without touching the bus. A bus that stalls past TIMEOUT_CYCLES
//   is abandoned with a timeout fault.
//
//   Parameters
//     TIMEOUT_CYCLES  1..65535  cycle budget from bus issue to response
//
//   Ports
//     clk            single clock, all logic on the rising edge
//     rst_n          synchronous active-low reset
//     mem_wr_en      level request, held by mSave until done/fault
//     mem_wr_addr    byte address of the C-List slot (sampled in IDLE only)
//     mem_wr_data    Golden Token to write (sampled in IDLE only)
//     mem_wr_done    one-cycle pulse on a successful write
//     wr_fault       one-cycle pulse on a failed write
//     wr_fault_code  01 misaligned, 10 bus error, 11 timeout; 00 otherwise
//     bridge_busy    high whenever the controller is not IDLE
//     bus            memory-bus write channel (master side)
// ----------------------------------------------------------------------------
module ctmm_mem_wr_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mem_wr_en,
  input  logic [63:0]                  mem_wr_addr,
  input  logic [63:0]                  mem_wr_data,
  output logic                         mem_wr_done,
  output logic                         wr_fault,
  output logic [1:0]                   wr_fault_code,
  output logic                         bridge_busy,
  ctmm_mem_wr_bridge_if.master         bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    RESP,
    DRAIN
  } state_t;

  typedef enum logic [1:0] {
    CODE_NONE     = 2'b00,
    CODE_MISALIGN = 2'b01,
    CODE_BUS_ERR  = 2'b10,
    CODE_TIMEOUT  = 2'b11
  } code_t;

  // This is the last counter value at which the bus may still answer.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        timed_out;

  // The counter runs across both ISSUE and WAIT_RSP. The budget covers the
  // whole issue-to-response window. A request accepted on the very last
  // cycle therefore leaves WAIT_RSP with no grace. Because the test is ">=",
  // a counter already past the limit still times out. It cannot wrap and
  // wait another 64K cycles.
  assign timed_out   = (cnt >= TIMEOUT_LAST);
  assign bridge_busy = (state != IDLE);

  // The controller and its registered outputs share one clocked block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      mem_wr_done       <= 1'b0;
      wr_fault          <= 1'b0;
      wr_fault_code     <= CODE_NONE;
      bus.bus_req_valid <= 1'b0;
      bus.bus_addr      <= '0;
      bus.bus_wdata     <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment. Every branch then
      // sees the pre-edge values, and the defaults below are overridden
      // cleanly by later assignments in the same edge.
      // The done/fault pulses are set on the edge that enters RESP. They are
      // cleared by default on every other edge, so they last exactly one
      // cycle and the code reads 00 while wr_fault is low.
      mem_wr_done   <= 1'b0;
      wr_fault      <= 1'b0;
      wr_fault_code <= CODE_NONE;

      case (state)
        IDLE: begin
          if (mem_wr_en) begin
            if (mem_wr_addr[2:0] != 3'b000) begin
              // Reject before any bus activity. Address and data stay as they were.
              wr_fault      <= 1'b1;
              wr_fault_code <= CODE_MISALIGN;
              state         <= RESP;
            end else begin
              bus.bus_addr      <= mem_wr_addr;
              bus.bus_wdata     <= mem_wr_data;
              bus.bus_req_valid <= 1'b1;
              cnt               <= '0;
              state             <= ISSUE;
            end
          end
        end

        ISSUE: begin
          cnt <= cnt + 16'd1;
          // Acceptance is tested first, so acceptance on the timeout cycle wins.
          if (bus.bus_req_ready) begin
            bus.bus_req_valid <= 1'b0;
            state             <= WAIT_RSP;
          end else if (timed_out) begin
            bus.bus_req_valid <= 1'b0;
            wr_fault          <= 1'b1;
            wr_fault_code     <= CODE_TIMEOUT;
            state             <= RESP;
          end
        end

        WAIT_RSP: begin
          cnt <= cnt + 16'd1;
          if (bus.bus_rsp_valid) begin
            if (bus.bus_rsp_err) begin
              wr_fault      <= 1'b1;
              wr_fault_code <= CODE_BUS_ERR;
            end else begin
              mem_wr_done   <= 1'b1;
            end
            state <= RESP;
          end else if (timed_out) begin
            wr_fault      <= 1'b1;
            wr_fault_code <= CODE_TIMEOUT;
            state         <= RESP;
          end
        end

        // The pulse is visible during RESP. Move on unconditionally.
        RESP: state <= DRAIN;

        // Hold here while mSave keeps the request asserted. This way one
        // request level can never start a second write.
        DRAIN: begin
          if (!mem_wr_en) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Structural invariants of the controller (simulation only).
  a_code_zero_when_idle: assert property (@(posedge clk) disable iff (!rst_n)
    !wr_fault |-> (wr_fault_code == CODE_NONE));
  a_done_fault_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_wr_done && wr_fault));
  a_valid_only_in_issue: assert property (@(posedge clk) disable iff (!rst_n)
    bus.bus_req_valid == (state == ISSUE));
  a_pulse_only_in_resp: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_wr_done || wr_fault) |-> (state == RESP));

endmodule : ctmm_mem_wr_bridge

// File: tb/tb_ctmm_mem_wr_bridge.sv
// ----------------------------------------------------------------------------
// tb_ctmm_mem_wr_bridge
//   Directed bench for ctmm_mem_wr_bridge with TIMEOUT_CYCLES = 8. Inputs are
//   driven, and outputs sampled, 1 time unit after each rising edge.
//   "Cycle n" is the interval after the n-th edge counted from the stimulus.
// ----------------------------------------------------------------------------
module tb_ctmm_mem_wr_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_wr_en;
  logic [63:0] mem_wr_addr;
  logic [63:0] mem_wr_data;
  logic        mem_wr_done;
  logic        wr_fault;
  logic [1:0]  wr_fault_code;
  logic        bridge_busy;

  int checks = 0;
  int errors = 0;
  int n_hs   = 0;   // accepted bus requests (valid && ready)
  int n_vld  = 0;   // cycles with bus_req_valid high

  ctmm_mem_wr_bridge_if bus_if ();

  ctmm_mem_wr_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_done  (mem_wr_done),
    .wr_fault     (wr_fault),
    .wr_fault_code(wr_fault_code),
    .bridge_busy  (bridge_busy),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  // Bus activity monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus_if.bus_req_valid) n_vld++;
    if (bus_if.bus_req_valid && bus_if.bus_req_ready) n_hs++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_wr_en            = 1'b0;
    mem_wr_addr          = '0;
    mem_wr_data          = '0;
    bus_if.bus_req_ready = 1'b0;
    bus_if.bus_rsp_valid = 1'b0;
    bus_if.bus_rsp_err   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    checks++; if (mem_wr_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", mem_wr_done); end
    checks++; if (wr_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", wr_fault); end
    checks++; if (wr_fault_code !== 2'b00) begin errors++; $display("FAIL reset_code got %b want 00", wr_fault_code); end
    checks++; if (bridge_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bridge_busy); end
    checks++; if (bus_if.bus_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus_if.bus_req_valid); end
    checks++; if (bus_if.bus_addr !== 64'h0) begin errors++; $display("FAIL reset_addr got %h want 0", bus_if.bus_addr); end
    checks++; if (bus_if.bus_wdata !== 64'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", bus_if.bus_wdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_write();
    int hs0;
    hs0 = n_hs;
    mem_wr_en = 1'b1; mem_wr_addr = 64'h1000; mem_wr_data = 64'hDEADBEEF00000001;
    bus_if.bus_req_ready = 1'b1;
    step();  // cycle 1
    checks++; if (bus_if.bus_req_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_c1 got %b want 1", bus_if.bus_req_valid); end
    checks++; if (bus_if.bus_addr !== 64'h1000) begin errors++; $display("FAIL basic_addr got %h want 1000", bus_if.bus_addr); end
    checks++; if (bus_if.bus_wdata !== 64'hDEADBEEF00000001) begin errors++; $display("FAIL basic_wdata got %h want deadbeef00000001", bus_if.bus_wdata); end
    checks++; if (bridge_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_c1 got %b want 1", bridge_busy); end
    mem_wr_addr = 64'h2000; mem_wr_data = 64'h0;  // must be ignored outside IDLE
    step();  // cycle 2
    checks++; if (bus_if.bus_req_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_c2 got %b want 0", bus_if.bus_req_valid); end
    checks++; if (bus_if.bus_addr !== 64'h1000) begin errors++; $display("FAIL basic_addr_held got %h want 1000", bus_if.bus_addr); end
    checks++; if (mem_wr_done !== 1'b0) begin errors++; $display("FAIL basic_done_c2 got %b want 0", mem_wr_done); end
    bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_err = 1'b0;
    step();  // cycle 3
    checks++; if (mem_wr_done !== 1'b1) begin errors++; $display("FAIL basic_done_c3 got %b want 1", mem_wr_done); end
    checks++; if (wr_fault !== 1'b0) begin errors++; $display("FAIL basic_fault_c3 got %b want 0", wr_fault); end
    checks++; if (wr_fault_code !== 2'b00) begin errors++; $display("FAIL basic_code_c3 got %b want 00", wr_fault_code); end
    bus_if.bus_rsp_valid = 1'b0; mem_wr_en = 1'b0;
    step();  // cycle 4: DRAIN
    checks++; if (mem_wr_done !== 1'b0) begin errors++; $display("FAIL basic_done_c4 got %b want 0", mem_wr_done); end
    checks++; if (bridge_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_c4 got %b want 1", bridge_busy); end
    step();  // cycle 5: IDLE
    checks++; if (bridge_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_c5 got %b want 0", bridge_busy); end
    checks++; if (n_hs - hs0 !== 1) begin errors++; $display("FAIL basic_writes got %0d want 1", n_hs - hs0); end
    idle_inputs();
  endtask

  task automatic test_misaligned();
    int v0;
    v0 = n_vld;
    mem_wr_en = 1'b1; mem_wr_addr = 64'h1004; mem_wr_data = 64'h55;
    step();  // cycle 1
    checks++; if (wr_fault !== 1'b1) begin errors++; $display("FAIL misal_fault got %b want 1", wr_fault); end
    checks++; if (wr_fault_code !== 2'b01) begin errors++; $display("FAIL misal_code got %b want 01", wr_fault_code); end
    checks++; if (mem_wr_done !== 1'b0) begin errors++; $display("FAIL misal_done got %b want 0", mem_wr_done); end
    step();  // cycle 2: DRAIN, request still held
    checks++; if (wr_fault !== 1'b0) begin errors++; $display("FAIL misal_fault_c2 got %b want 0", wr_fault); end
    checks++; if (wr_fault_code !== 2'b00) begin errors++; $display("FAIL misal_code_c2 got %b want 00", wr_fault_code); end
    checks++; if (bridge_busy !== 1'b1) begin errors++; $display("FAIL misal_busy_c2 got %b want 1", bridge_busy); end
    mem_wr_en = 1'b0;
    step();
    checks++; if (bridge_busy !== 1'b0) begin errors++; $display("FAIL misal_busy_c3 got %b want 0", bridge_busy); end
    checks++; if (n_vld - v0 !== 0) begin errors++; $display("FAIL misal_no_valid got %0d want 0", n_vld - v0); end
    idle_inputs();
  endtask

  task automatic test_timeout();
    mem_wr_en = 1'b1; mem_wr_addr = 64'h3000; mem_wr_data = 64'h33;
    bus_if.bus_req_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();  // cycles 1..8
      checks++; if (bus_if.bus_req_valid !== 1'b1) begin errors++; $display("FAIL tmo_valid_c%0d got %b want 1", k, bus_if.bus_req_valid); end
    end
    step();  // cycle 9
    checks++; if (bus_if.bus_req_valid !== 1'b0) begin errors++; $display("FAIL tmo_valid_c9 got %b want 0", bus_if.bus_req_valid); end
    checks++; if (wr_fault !== 1'b1) begin errors++; $display("FAIL tmo_fault got %b want 1", wr_fault); end
    checks++; if (wr_fault_code !== 2'b11) begin errors++; $display("FAIL tmo_code got %b want 11", wr_fault_code); end
    mem_wr_en = 1'b0;
    bus_if.bus_rsp_valid = 1'b1;  // late response, must be ignored
    step();  // cycle 10: DRAIN
    checks++; if (mem_wr_done !== 1'b0) begin errors++; $display("FAIL tmo_late_done_c10 got %b want 0", mem_wr_done); end
    checks++; if (wr_fault !== 1'b0) begin errors++; $display("FAIL tmo_late_fault_c10 got %b want 0", wr_fault); end
    step();  // cycle 11: IDLE
    bus_if.bus_rsp_valid = 1'b0;
    step();  // cycle 12
    checks++; if (mem_wr_done !== 1'b0) begin errors++; $display("FAIL tmo_late_done_c12 got %b want 0", mem_wr_done); end
    checks++; if (bridge_busy !== 1'b0) begin errors++; $display("FAIL tmo_busy_c12 got %b want 0", bridge_busy); end
    idle_inputs();
  endtask

  task automatic test_bus_error();
    int hs0;
    hs0 = n_hs;
    mem_wr_en = 1'b1; mem_wr_addr = 64'h4008; mem_wr_data = 64'h44;
    bus_if.bus_req_ready = 1'b1;
    step();  // cycle 1
    step();  // cycle 2
    bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_err = 1'b1;
    step();  // cycle 3
    checks++; if (wr_fault !== 1'b1) begin errors++; $display("FAIL berr_fault got %b want 1", wr_fault); end
    checks++; if (wr_fault_code !== 2'b10) begin errors++; $display("FAIL berr_code got %b want 10", wr_fault_code); end
    checks++; if (mem_wr_done !== 1'b0) begin errors++; $display("FAIL berr_done got %b want 0", mem_wr_done); end
    bus_if.bus_rsp_valid = 1'b0; bus_if.bus_rsp_err = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      step();  // request held with ready high: no second write
      checks++; if (bus_if.bus_req_valid !== 1'b0) begin errors++; $display("FAIL berr_valid_c%0d got %b want 0", k, bus_if.bus_req_valid); end
      checks++; if (bridge_busy !== 1'b1) begin errors++; $display("FAIL berr_busy_c%0d got %b want 1", k, bridge_busy); end
    end
    checks++; if (n_hs - hs0 !== 1) begin errors++; $display("FAIL berr_writes got %0d want 1", n_hs - hs0); end
    mem_wr_en = 1'b0;
    step();
    checks++; if (bridge_busy !== 1'b0) begin errors++; $display("FAIL berr_busy_end got %b want 0", bridge_busy); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    mem_wr_en = 1'b1; mem_wr_addr = 64'h5000; mem_wr_data = 64'h1111;
    bus_if.bus_req_ready = 1'b1;
    step();  // cycle 1: ISSUE
    step();  // cycle 2: WAIT_RSP
    checks++; if (bridge_busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_wait got %b want 1", bridge_busy); end
    rst_n = 1'b0;
    step();  // cycle 3
    checks++; if (bus_if.bus_req_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", bus_if.bus_req_valid); end
    checks++; if (bus_if.bus_addr !== 64'h0) begin errors++; $display("FAIL rmid_addr got %h want 0", bus_if.bus_addr); end
    checks++; if (bus_if.bus_wdata !== 64'h0) begin errors++; $display("FAIL rmid_wdata got %h want 0", bus_if.bus_wdata); end
    checks++; if (bridge_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", bridge_busy); end
    checks++; if (mem_wr_done !== 1'b0 || wr_fault !== 1'b0 || wr_fault_code !== 2'b00) begin errors++; $display("FAIL rmid_pulses got %b%b%b want 0000", mem_wr_done, wr_fault, wr_fault_code); end
    rst_n = 1'b1; mem_wr_addr = 64'h6000; mem_wr_data = 64'h2222;
    step();  // cycle 4: accepted on the first cycle out of reset
    checks++; if (bus_if.bus_req_valid !== 1'b1) begin errors++; $display("FAIL rmid_new_valid got %b want 1", bus_if.bus_req_valid); end
    checks++; if (bus_if.bus_addr !== 64'h6000) begin errors++; $display("FAIL rmid_new_addr got %h want 6000", bus_if.bus_addr); end
    step();  // cycle 5
    bus_if.bus_rsp_valid = 1'b1;
    step();  // cycle 6
    checks++; if (mem_wr_done !== 1'b1) begin errors++; $display("FAIL rmid_new_done got %b want 1", mem_wr_done); end
    bus_if.bus_rsp_valid = 1'b0; mem_wr_en = 1'b0;
    step();
    step();
    idle_inputs();
  endtask

  task automatic test_ready_on_timeout();
    mem_wr_en = 1'b1; mem_wr_addr = 64'h7000; mem_wr_data = 64'h77;
    bus_if.bus_req_ready = 1'b0;
    for (int k = 1; k <= 7; k++) step();
    step();  // cycle 8: counter at TIMEOUT_CYCLES-1
    checks++; if (bus_if.bus_req_valid !== 1'b1) begin errors++; $display("FAIL rto_valid_c8 got %b want 1", bus_if.bus_req_valid); end
    bus_if.bus_req_ready = 1'b1;
    step();  // cycle 9: WAIT_RSP
    checks++; if (bus_if.bus_req_valid !== 1'b0) begin errors++; $display("FAIL rto_valid_c9 got %b want 0", bus_if.bus_req_valid); end
    checks++; if (wr_fault !== 1'b0) begin errors++; $display("FAIL rto_fault_c9 got %b want 0", wr_fault); end
    bus_if.bus_req_ready = 1'b0; bus_if.bus_rsp_valid = 1'b1;
    step();  // cycle 10
    checks++; if (mem_wr_done !== 1'b1) begin errors++; $display("FAIL rto_done got %b want 1", mem_wr_done); end
    checks++; if (wr_fault !== 1'b0) begin errors++; $display("FAIL rto_fault_c10 got %b want 0", wr_fault); end
    bus_if.bus_rsp_valid = 1'b0; mem_wr_en = 1'b0;
    step();
    step();
    idle_inputs();
  endtask

  task automatic test_en_drop();
    mem_wr_en = 1'b1; mem_wr_addr = 64'h8000; mem_wr_data = 64'h88;
    bus_if.bus_req_ready = 1'b0;
    step();  // cycle 1
    mem_wr_en = 1'b0;
    step();  // cycle 2: still issuing
    checks++; if (bus_if.bus_req_valid !== 1'b1) begin errors++; $display("FAIL drop_valid_c2 got %b want 1", bus_if.bus_req_valid); end
    bus_if.bus_req_ready = 1'b1;
    step();  // cycle 3
    checks++; if (bridge_busy !== 1'b1) begin errors++; $display("FAIL drop_busy_c3 got %b want 1", bridge_busy); end
    bus_if.bus_req_ready = 1'b0; bus_if.bus_rsp_valid = 1'b1;
    step();  // cycle 4
    checks++; if (mem_wr_done !== 1'b1) begin errors++; $display("FAIL drop_done got %b want 1", mem_wr_done); end
    bus_if.bus_rsp_valid = 1'b0;
    step();  // cycle 5: DRAIN
    checks++; if (mem_wr_done !== 1'b0) begin errors++; $display("FAIL drop_done_c5 got %b want 0", mem_wr_done); end
    step();  // cycle 6: IDLE
    checks++; if (bridge_busy !== 1'b0) begin errors++; $display("FAIL drop_busy_c6 got %b want 0", bridge_busy); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_misaligned();
    test_timeout();
    test_bus_error();
    test_reset_mid();
    test_ready_on_timeout();
    test_en_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ctmm_mem_wr_bridge
